// File: rtl/sopc_data_bus_pkg.sv
// Shared definitions for the SoPC data-side bus: FSM states, default address map
// and timeout, plus a helper for sizing slave index fields.
package sopc_data_bus_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE   = 2'd0,
        BUS_ACCESS = 2'd1,
        BUS_RESP   = 2'd2
    } bus_state_e;

    localparam int DEF_NUM_SLAVES = 4;
    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_TIMEOUT    = 15;

    // Slave 0 (RAM) sits in the LSBs; every default window is 16 MiB.
    localparam logic [DEF_NUM_SLAVES*DEF_ADDR_W-1:0] DEF_SLAVE_BASE =
        {32'h1000_0000, 32'h0400_0000, 32'h0200_0000, 32'h0000_0000};
    localparam logic [DEF_NUM_SLAVES*DEF_ADDR_W-1:0] DEF_SLAVE_MASK =
        {DEF_NUM_SLAVES{32'hFF00_0000}};

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sopc_data_bus_addr_decoder.sv
// Combinational priority address decoder: maps a byte address onto a slave index,
// the lowest-numbered matching slave winning when windows overlap.
module sopc_data_bus_addr_decoder
    import sopc_data_bus_pkg::*;
#(
    parameter int NUM_SLAVES = DEF_NUM_SLAVES,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int IDX_W      = idx_width(DEF_NUM_SLAVES),
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = DEF_SLAVE_MASK
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    // Scanning downwards lets the lowest matching index overwrite any higher one.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sopc_data_bus.sv
// Data-side interconnect for the OpenMIPS SoPC: decodes CPU MEM-stage requests onto
// memory-mapped slaves, stalls the CPU across wait states and reports bus errors.
module sopc_data_bus
    import sopc_data_bus_pkg::*;
#(
    parameter int NUM_SLAVES = DEF_NUM_SLAVES,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = DEF_SLAVE_MASK,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_ce_i,
    input  logic                         cpu_we_i,
    input  logic [ADDR_W-1:0]            cpu_addr_i,
    input  logic [DATA_W/8-1:0]          cpu_sel_i,
    input  logic [DATA_W-1:0]            cpu_data_i,
    output logic [DATA_W-1:0]            cpu_data_o,
    output logic                         cpu_stall_o,
    output logic                         cpu_err_o,
    output logic [NUM_SLAVES-1:0]        s_ce_o,
    output logic                         s_we_o,
    output logic [ADDR_W-1:0]            s_addr_o,
    output logic [DATA_W/8-1:0]          s_sel_o,
    output logic [DATA_W-1:0]            s_data_o,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_data_i,
    input  logic [NUM_SLAVES-1:0]        s_ack_i
);

    localparam int IDX_W = idx_width(NUM_SLAVES);
    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    bus_state_e        state, state_next;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [SEL_W-1:0]  sel_q;
    logic [DATA_W-1:0] wdata_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt;

    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic              ack_sel;
    logic [DATA_W-1:0] rdata_sel;
    logic              timed_out;

    sopc_data_bus_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .IDX_W      (IDX_W),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decoder (
        .addr (cpu_addr_i),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    // Only the latched slave's ack and data matter; the rest is cross-talk.
    assign ack_sel   = s_ack_i[idx_q];
    assign rdata_sel = s_data_i[idx_q*DATA_W +: DATA_W];
    assign timed_out = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BUS_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_next;
            case (state)
                BUS_IDLE: begin
                    if (cpu_ce_i && dec_hit) begin
                        we_q    <= cpu_we_i;
                        addr_q  <= cpu_addr_i;
                        sel_q   <= cpu_sel_i;
                        wdata_q <= cpu_data_i;
                        idx_q   <= dec_idx;
                        cnt     <= '0;
                    end else if (cpu_ce_i) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                BUS_ACCESS: begin
                    if (ack_sel) begin
                        rdata_q <= we_q ? '0 : rdata_sel;
                        err_q   <= 1'b0;
                    end else if (timed_out) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BUS_IDLE:   if (cpu_ce_i) state_next = dec_hit ? BUS_ACCESS : BUS_RESP;
            BUS_ACCESS: if (ack_sel || timed_out) state_next = BUS_RESP;
            BUS_RESP:   state_next = BUS_IDLE;
            default:    state_next = BUS_IDLE;
        endcase
    end

    always_comb begin
        s_ce_o = '0;
        if (state == BUS_ACCESS) s_ce_o[idx_q] = 1'b1;
    end

    // RESP deliberately drops the stall so the CPU consumes the response that cycle.
    assign cpu_stall_o = !rst && ((state == BUS_IDLE && cpu_ce_i) || state == BUS_ACCESS);

    assign cpu_data_o = rdata_q;
    assign cpu_err_o  = err_q;
    assign s_we_o     = we_q;
    assign s_addr_o   = addr_q;
    assign s_sel_o    = sel_q;
    assign s_data_o   = wdata_q;

endmodule

// File: tb/tb_sopc_data_bus.sv
// Self-checking bench for sopc_data_bus: a transaction-level model predicts every
// cycle's outputs while directed and randomized requests run against the DUT.
module tb_sopc_data_bus;

    localparam int NS = 4;
    localparam int TO = 15;
    localparam logic [31:0] MODEL_BASE [NS] = '{32'h0000_0000, 32'h0200_0000, 32'h0400_0000, 32'h1000_0000};
    localparam logic [31:0] MODEL_MASK = 32'hFF00_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_ce_i, cpu_we_i;
    logic [31:0]  cpu_addr_i, cpu_data_i;
    logic [3:0]   cpu_sel_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o, cpu_err_o;
    logic [3:0]   s_ce_o;
    logic         s_we_o;
    logic [31:0]  s_addr_o, s_data_o;
    logic [3:0]   s_sel_o;
    logic [127:0] s_data_i;
    logic [3:0]   s_ack_i;

    int n_checks = 0;
    int n_pass = 0;
    int stall_count = 0;
    int ce_count = 0;
    bit compare_en = 1'b0;

    logic        exp_stall;
    logic [3:0]  exp_ce;
    logic [31:0] held_data;
    logic        held_err;
    bit          exp_access;
    logic        exp_we;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_sel;

    sopc_data_bus dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_ce_i    (cpu_ce_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_sel_i   (cpu_sel_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_stall_o (cpu_stall_o),
        .cpu_err_o   (cpu_err_o),
        .s_ce_o      (s_ce_o),
        .s_we_o      (s_we_o),
        .s_addr_o    (s_addr_o),
        .s_sel_o     (s_sel_o),
        .s_data_o    (s_data_o),
        .s_data_i    (s_data_i),
        .s_ack_i     (s_ack_i)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected)
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        if (compare_en) begin
            check_output("stall", 64'(cpu_stall_o), 64'(exp_stall));
            check_output("s_ce", 64'(s_ce_o), 64'(exp_ce));
            check_output("cpu_data", 64'(cpu_data_o), 64'(held_data));
            check_output("cpu_err", 64'(cpu_err_o), 64'(held_err));
            if (exp_access) begin
                check_output("s_we", 64'(s_we_o), 64'(exp_we));
                check_output("s_addr", 64'(s_addr_o), 64'(exp_addr));
                check_output("s_sel", 64'(s_sel_o), 64'(exp_sel));
                check_output("s_wdata", 64'(s_data_o), 64'(exp_wdata));
            end
            if (cpu_stall_o) stall_count++;
            if (s_ce_o != 4'b0) ce_count++;
        end
    end

    function automatic void model_decode(input logic [31:0] addr, output bit hit, output int idx);
        hit = 1'b0;
        idx = 0;
        for (int i = 0; i < NS; i++) begin
            if (!hit && (addr & MODEL_MASK) == MODEL_BASE[i]) begin
                hit = 1'b1;
                idx = i;
            end
        end
    endfunction

    function automatic logic [31:0] rand_addr();
        int r = $urandom_range(0, 4);
        logic [23:0] low = 24'($urandom);
        if (r < NS) return MODEL_BASE[r] | {8'h00, low};
        return {8'($urandom_range(17, 255)), low};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_noise();
        cpu_ce_i   = 1'($urandom);
        cpu_we_i   = 1'($urandom);
        cpu_addr_i = $urandom;
        cpu_sel_i  = 4'($urandom);
        cpu_data_i = $urandom;
        s_data_i   = {$urandom, $urandom, $urandom, $urandom};
        s_ack_i    = 4'($urandom);
    endtask

    task automatic idle_cycle();
        drive_noise();
        cpu_ce_i   = 1'b0;
        exp_stall  = 1'b0;
        exp_ce     = 4'b0;
        exp_access = 1'b0;
        next_cycle();
    endtask

    // wait_cyc >= TO means the selected slave never acknowledges.
    task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                                  input logic [31:0] wdata, input logic [31:0] rdata, input int wait_cyc);
        bit hit;
        int idx;
        int n_acc;
        bit got_ack;
        logic [3:0] onehot;
        model_decode(addr, hit, idx);
        onehot = 4'b0001 << idx;

        drive_noise();
        cpu_ce_i   = 1'b1;
        cpu_we_i   = we;
        cpu_addr_i = addr;
        cpu_sel_i  = sel;
        cpu_data_i = wdata;
        exp_stall  = 1'b1;
        exp_ce     = 4'b0;
        exp_access = 1'b0;
        next_cycle();

        if (hit) begin
            got_ack = (wait_cyc < TO);
            n_acc   = got_ack ? wait_cyc + 1 : TO;
            for (int k = 0; k < n_acc; k++) begin
                drive_noise();
                s_data_i[idx*32 +: 32] = rdata;
                s_ack_i = s_ack_i & ~onehot;
                if (got_ack && k == wait_cyc) s_ack_i = s_ack_i | onehot;
                exp_stall  = 1'b1;
                exp_ce     = onehot;
                exp_access = 1'b1;
                exp_we     = we;
                exp_addr   = addr;
                exp_sel    = sel;
                exp_wdata  = wdata;
                next_cycle();
            end
            held_data = (got_ack && !we) ? rdata : 32'h0;
            held_err  = !got_ack;
        end else begin
            held_data = 32'h0;
            held_err  = 1'b1;
        end

        drive_noise();
        exp_stall  = 1'b0;
        exp_ce     = 4'b0;
        exp_access = 1'b0;
        next_cycle();
    endtask

    task automatic reset_mid_access();
        drive_noise();
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_0020;
        cpu_sel_i  = 4'hF;
        exp_stall  = 1'b1;
        exp_ce     = 4'b0;
        exp_access = 1'b0;
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            drive_noise();
            s_ack_i    = s_ack_i & 4'b1110;
            rst        = (k == 1);
            exp_stall  = (k == 0);
            exp_ce     = 4'b0001;
            exp_access = 1'b1;
            exp_we     = 1'b0;
            exp_addr   = 32'h0000_0020;
            exp_sel    = 4'hF;
            exp_wdata  = cpu_data_i;
            if (k == 0) exp_wdata = 32'hx;
            exp_access = (k == 0) ? 1'b0 : 1'b0;
            next_cycle();
        end
        rst       = 1'b0;
        held_data = 32'h0;
        held_err  = 1'b0;
        idle_cycle();
    endtask

    initial begin
        rst        = 1'b1;
        cpu_ce_i   = 1'b0;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0;
        cpu_sel_i  = 4'h0;
        cpu_data_i = 32'h0;
        s_data_i   = '0;
        s_ack_i    = 4'h0;
        held_data  = 32'h0;
        held_err   = 1'b0;
        exp_stall  = 1'b0;
        exp_ce     = 4'b0;
        exp_access = 1'b0;
        next_cycle();
        next_cycle();
        compare_en = 1'b1;
        next_cycle();
        rst = 1'b0;
        idle_cycle();

        stall_count = 0; ce_count = 0;
        apply_stimulus(1'b0, 32'h0000_0010, 4'hF, 32'h0, 32'hDEAD_BEEF, 0);
        check_output("ram_read_data_lit", 64'(cpu_data_o), 64'h0000_0000_DEAD_BEEF);
        check_output("ram_read_err_lit", 64'(cpu_err_o), 64'h0);
        check_output("ram_read_stalls_lit", 64'(stall_count), 64'd2);

        stall_count = 0; ce_count = 0;
        apply_stimulus(1'b1, 32'h0200_0004, 4'b1100, 32'h1234_5678, 32'hFFFF_FFFF, 3);
        check_output("timer_write_ce_cycles_lit", 64'(ce_count), 64'd4);
        check_output("timer_write_err_lit", 64'(cpu_err_o), 64'h0);
        check_output("timer_write_data_lit", 64'(cpu_data_o), 64'h0);

        stall_count = 0; ce_count = 0;
        apply_stimulus(1'b0, 32'h8000_0000, 4'hF, 32'h0, 32'h5555_5555, 0);
        check_output("unmapped_stalls_lit", 64'(stall_count), 64'd1);
        check_output("unmapped_ce_cycles_lit", 64'(ce_count), 64'd0);
        check_output("unmapped_err_lit", 64'(cpu_err_o), 64'h1);

        stall_count = 0; ce_count = 0;
        apply_stimulus(1'b0, 32'h0400_0000, 4'hF, 32'h0, 32'h7777_7777, 1000);
        check_output("timeout_ce_cycles_lit", 64'(ce_count), 64'd15);
        check_output("timeout_stalls_lit", 64'(stall_count), 64'd16);
        check_output("timeout_err_lit", 64'(cpu_err_o), 64'h1);
        check_output("timeout_data_lit", 64'(cpu_data_o), 64'h0);

        reset_mid_access();
        check_output("reset_err_lit", 64'(cpu_err_o), 64'h0);
        apply_stimulus(1'b0, 32'h0000_0040, 4'hF, 32'h0, 32'h0BAD_F00D, 1);
        check_output("after_reset_data_lit", 64'(cpu_data_o), 64'h0000_0000_0BAD_F00D);

        apply_stimulus(1'b0, 32'h0000_0100, 4'hF, 32'h0, 32'hCAFE_0001, 0);
        check_output("b2b_first_data_lit", 64'(cpu_data_o), 64'h0000_0000_CAFE_0001);
        apply_stimulus(1'b0, 32'h1000_0000, 4'hF, 32'h0, 32'hCAFE_0003, 0);
        check_output("b2b_second_data_lit", 64'(cpu_data_o), 64'h0000_0000_CAFE_0003);

        for (int t = 0; t < 200; t++) begin
            int gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) idle_cycle();
            apply_stimulus(1'($urandom), rand_addr(), 4'($urandom), $urandom, $urandom,
                           $urandom_range(0, TO + 3));
        end
        idle_cycle();
        idle_cycle();

        compare_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
